truth_table_checker: RTL and testbench
======================================

Name: truth_table_checker

Overview:
Synthesizable response-checking counterpart to the gate-level stimulus benches used for the combinational lab tasks. On a start request it sweeps all 2^N_IN input combinations onto a combinational DUT, waits a fixed settle time, and samples the DUT's single-bit response. It compares each response against an expected truth table and reports pass/fail, mismatch count and first failing index. It sits beside the lab gate modules, for example the 2-input x/y -> z tasks, so an experiment can self-check on the board without a simulator.

Parameters:
N_IN, 2, number of DUT inputs; vectors swept = 2^N_IN.
SETTLE, 1, cycles stimulus is held before sampling; legal range >= 1.

Ports:
clk  input  1  single system clock; all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  run request; accepted only in IDLE.
exp_table  input  2^N_IN  expected response; bit i = expected resp for stim == i; latched on accepted start.
stim  output  N_IN  drive to DUT inputs; MSB = first DUT input (x), LSB = last (y).
resp  input  1  DUT output (z).
busy  output  1  high from the cycle after start acceptance through the last SAMPLE cycle.
done  output  1  one-cycle pulse at end of sweep.
pass  output  1  valid from done onward: 1 when err_count == 0.
err_count  output  N_IN+1  number of mismatching vectors.
fail_valid  output  1  at least one mismatch recorded this run.
first_fail_idx  output  N_IN  stim index of the first mismatch.

Behaviour:
- One clock. Reset is synchronous and active-low: when rst_n = 0 at a clk edge, the FSM goes to IDLE and stim, busy, done, pass, err_count, fail_valid and first_fail_idx all go to 0.
- Reset mid-sweep aborts the run. No done pulse is produced and results are cleared.
- FSM states: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE: when start = 1, latch exp_table, clear err_count/pass/fail_valid/first_fail_idx, set idx = 0 and stim = 0, clear the settle counter, and go to SETTLE.
- SETTLE: stim = idx and busy = 1. Stay for exactly SETTLE cycles, then go to SAMPLE.
- SAMPLE: stim is held at idx. At the closing edge, compare resp against exp_table[idx].
  - On a mismatch, increment err_count.
  - On a mismatch with fail_valid = 0, also set fail_valid = 1 and first_fail_idx = idx.
  - If idx == 2^N_IN-1, go to FINISH. Otherwise increment idx and go to SETTLE.
- FINISH: done = 1 and busy = 0 for one cycle. pass = (err_count == 0) is registered into this cycle. Then go to IDLE.
- Latency: with start sampled at edge T0, done is high in cycle T0 + 1 + 2^N_IN*(SETTLE+1). With defaults that is T0+9.
- Result outputs (pass, err_count, fail_valid, first_fail_idx) and the final stim value hold until the next accepted start or reset.
- start while busy or in FINISH is ignored. There is no queuing.
- start held high continuously re-triggers a new run from IDLE after each FINISH.
- Changes to exp_table after acceptance have no effect on the current run.
- err_count cannot overflow: its width is N_IN+1, and its maximum value is 2^N_IN.

Decomposition:
- Shared package: FSM state encoding localparams (IDLE/SETTLE/SAMPLE/FINISH) and a helper function returning the vector count 2^N_IN.
- Settle counter width is derived from SETTLE via $clog2.
- Single module. No sub-module is warranted, because the settle counter is trivial.

Test Plan:
1. XOR DUT (z = x^y), exp_table = 4'b0110, start one cycle -> stim sequence 00,01,10,11, each held 2 cycles; done at T0+9; pass = 1, err_count = 0, fail_valid = 0.
2. AND DUT (truth table 4'b1000), exp_table = 4'b0110 -> mismatches at idx 1, 2 and 3; err_count = 3, fail_valid = 1, first_fail_idx = 1, pass = 0.
3. Extra start pulses at T0+3 and T0+8 during a run -> ignored; exactly one done pulse at T0+9; results are those of scenario 1.
4. rst_n = 0 for one edge at T0+4 mid-run -> next cycle all outputs 0, state IDLE, no done. A new start then produces a full, correct run.
5. SETTLE = 3, DUT = XOR followed by a 2-cycle register delay, exp_table = 4'b0110 -> done at T0+17, pass = 1. The same DUT with SETTLE = 1 -> pass = 0, err_count > 0.
6. resp tied to 0, exp_table = 4'b0000 -> pass = 1. Then rerun with exp_table = 4'b1111 -> err_count = 4, first_fail_idx = 0, showing results from the previous run are cleared.

Source files
------------

// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the truth-table checker: FSM state encoding and sweep sizing.
package truth_table_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_FINISH = 2'd3
   } state_e;

   function automatic int num_vectors(input int n_in);
      return 1 << n_in;
   endfunction

endpackage

// File: rtl/truth_table_checker.sv
// Sweeps every input combination onto a combinational DUT, samples its single-bit
// response after a settle time and scores it against an expected truth table.
module truth_table_checker
   import truth_table_checker_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [(2**N_IN)-1:0]   exp_table,
   output logic [N_IN-1:0]        stim,
   input  logic                   resp,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [N_IN:0]          err_count,
   output logic                   fail_valid,
   output logic [N_IN-1:0]        first_fail_idx
);

   localparam int                NV       = num_vectors(N_IN);
   localparam int                CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SETTLE - 1);
   localparam logic [N_IN-1:0]   LAST_IDX = N_IN'(NV - 1);

   state_e              state_q;
   logic [NV-1:0]       exp_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [N_IN-1:0]     stim_q;
   logic                busy_q;
   logic                done_q;
   logic                pass_q;
   logic [N_IN:0]       err_count_q;
   logic [N_IN:0]       err_count_d;
   logic                fail_valid_q;
   logic [N_IN-1:0]     first_fail_idx_q;
   logic                mismatch;

   // stim_q doubles as the sweep index, so the DUT sees exactly the vector being scored.
   assign mismatch    = (resp != exp_q[stim_q]);
   assign err_count_d = mismatch ? (err_count_q + (N_IN+1)'(1)) : err_count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q          <= ST_IDLE;
         cnt_q            <= '0;
         stim_q           <= '0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         pass_q           <= 1'b0;
         err_count_q      <= '0;
         fail_valid_q     <= 1'b0;
         first_fail_idx_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  exp_q            <= exp_table;
                  err_count_q      <= '0;
                  pass_q           <= 1'b0;
                  fail_valid_q     <= 1'b0;
                  first_fail_idx_q <= '0;
                  stim_q           <= '0;
                  cnt_q            <= '0;
                  busy_q           <= 1'b1;
                  state_q          <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt_q == CNT_MAX) begin
                  cnt_q   <= '0;
                  state_q <= ST_SAMPLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_SAMPLE: begin
               err_count_q <= err_count_d;
               if (mismatch && !fail_valid_q) begin
                  fail_valid_q     <= 1'b1;
                  first_fail_idx_q <= stim_q;
               end
               // pass must include the verdict of the last vector scored on this same edge.
               if (stim_q == LAST_IDX) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_count_d == '0);
                  state_q <= ST_FINISH;
               end else begin
                  stim_q  <= stim_q + N_IN'(1);
                  state_q <= ST_SETTLE;
               end
            end
            ST_FINISH: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign stim           = stim_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_count_q;
   assign fail_valid     = fail_valid_q;
   assign first_fail_idx = first_fail_idx_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: two instances (SETTLE=1 and SETTLE=3) scored every cycle
// against a cycle-offset model, plus directed scenarios with hand-computed results.
module tb_truth_table_checker;

   localparam int NV = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n  = 1'b0;
   logic       start0 = 1'b0, start1 = 1'b0;
   logic [3:0] exp0   = 4'b0, exp1 = 4'b0;
   logic [1:0] sel    = 2'd0;

   logic [1:0] stim0, stim1, ffi0, ffi1;
   logic [2:0] err0, err1;
   logic       busy0, done0, pass0, fv0, resp0;
   logic       busy1, done1, pass1, fv1, resp1;
   logic [1:0] dl0a = 2'b0, dl0b = 2'b0, dl1a = 2'b0, dl1b = 2'b0;

   // Target DUTs: combinational XOR / AND / constant 0, or XOR behind two register stages.
   always @(posedge clk) begin
      dl0a <= stim0; dl0b <= dl0a;
      dl1a <= stim1; dl1b <= dl1a;
   end
   assign resp0 = (sel == 2'd0) ? ^stim0 :
                  (sel == 2'd1) ? &stim0 :
                  (sel == 2'd2) ? 1'b0   : ^dl0b;
   assign resp1 = ^dl1b;

   truth_table_checker #(.N_IN(2), .SETTLE(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .exp_table(exp0), .stim(stim0),
      .resp(resp0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
      .fail_valid(fv0), .first_fail_idx(ffi0));

   truth_table_checker #(.N_IN(2), .SETTLE(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .exp_table(exp1), .stim(stim1),
      .resp(resp1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .fail_valid(fv1), .first_fail_idx(ffi1));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // Model: a run is tracked as a cycle offset c from the accepting edge; cycle c+1 of
   // the run shows vector c/(S+1), and every (S+1)-th cycle closes with a sample.
   bit         m_ready = 1'b0;
   bit         m_act[2], m_busy[2], m_done[2], m_pass[2], m_fv[2];
   int         m_c[2], m_err[2], m_ffi[2], m_stim[2];
   logic [3:0] m_exp[2];

   task automatic model_step(input int i, input logic st, input logic r, input logic [3:0] e);
      int s, len, j;
      s   = (i == 0) ? 1 : 3;
      len = NV * (s + 1);
      if (!rst_n) begin
         m_act[i] = 0; m_stim[i] = 0; m_busy[i] = 0; m_done[i] = 0;
         m_pass[i] = 0; m_err[i] = 0; m_fv[i] = 0; m_ffi[i] = 0;
         return;
      end
      if (m_act[i]) begin
         j = m_c[i] + 1;
         if (j <= len && (j % (s + 1)) == 0 && r != m_exp[i][(j - 1) / (s + 1)]) begin
            m_err[i]++;
            if (!m_fv[i]) begin
               m_fv[i]  = 1;
               m_ffi[i] = (j - 1) / (s + 1);
            end
         end
         if (j == len) m_pass[i] = (m_err[i] == 0);
         if (j == len + 1) m_act[i] = 0;
         else m_c[i]++;
      end else if (st) begin
         m_act[i] = 1; m_c[i] = 0; m_exp[i] = e;
         m_err[i] = 0; m_pass[i] = 0; m_fv[i] = 0; m_ffi[i] = 0;
      end
      if (m_act[i]) begin
         j = m_c[i] + 1;
         m_busy[i] = (j <= len);
         m_done[i] = (j == len + 1);
         m_stim[i] = (j <= len) ? (j - 1) / (s + 1) : NV - 1;
      end else begin
         m_busy[i] = 0;
         m_done[i] = 0;
      end
   endtask

   always @(posedge clk) begin
      model_step(0, start0, resp0, exp0);
      model_step(1, start1, resp1, exp1);
      m_ready = 1'b1;
   end

   task automatic cmp(input int i, input logic [1:0] st, input logic b, input logic d,
                      input logic p, input logic [2:0] er, input logic f, input logic [1:0] ff);
      chk($sformatf("stim%0d", i),  32'(st), 32'(m_stim[i]));
      chk($sformatf("busy%0d", i),  32'(b),  32'(m_busy[i]));
      chk($sformatf("done%0d", i),  32'(d),  32'(m_done[i]));
      chk($sformatf("pass%0d", i),  32'(p),  32'(m_pass[i]));
      chk($sformatf("err%0d", i),   32'(er), 32'(m_err[i]));
      chk($sformatf("fv%0d", i),    32'(f),  32'(m_fv[i]));
      chk($sformatf("ffi%0d", i),   32'(ff), 32'(m_ffi[i]));
   endtask

   always @(negedge clk) begin
      if (m_ready) begin
         cmp(0, stim0, busy0, done0, pass0, err0, fv0, ffi0);
         cmp(1, stim1, busy1, done1, pass1, err1, fv1, ffi1);
      end
   end

   // Start a run on instance 0; lat = run cycle in which done is seen (cycle 1 follows
   // the accepting edge). Extra start pulses land in cycles p1/p2; exp_table is
   // scrambled once the run is accepted.
   task automatic run0(input logic [3:0] e, input int p1, input int p2, output int lat);
      @(negedge clk);
      exp0   = e;
      start0 = 1'b1;
      @(negedge clk);
      exp0   = ~e;
      lat    = 1;
      start0 = (lat == p1 || lat == p2);
      while (!done0 && lat < 40) begin
         @(negedge clk);
         lat++;
         start0 = (lat == p1 || lat == p2);
      end
      start0 = 1'b0;
   endtask

   task automatic run1(input logic [3:0] e, output int lat);
      @(negedge clk);
      exp1   = e;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      exp1   = ~e;
      lat    = 1;
      while (!done1 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, nd;
      repeat (2) @(negedge clk);
      chk("rst_stim", 32'(stim0), 0);
      chk("rst_busy", 32'(busy0), 0);
      chk("rst_err",  32'(err0),  0);
      rst_n = 1'b1;
      @(negedge clk);

      // XOR against its own table
      sel = 2'd0;
      run0(4'b0110, 0, 0, lat);
      chk("s1_latency", 32'(lat), 9);
      chk("s1_pass", 32'(pass0), 1);
      chk("s1_err",  32'(err0),  0);
      chk("s1_fv",   32'(fv0),   0);
      repeat (2) @(negedge clk);

      // AND against the XOR table
      sel = 2'd1;
      run0(4'b0110, 0, 0, lat);
      chk("s2_latency", 32'(lat), 9);
      chk("s2_err",  32'(err0), 3);
      chk("s2_fv",   32'(fv0),  1);
      chk("s2_ffi",  32'(ffi0), 1);
      chk("s2_pass", 32'(pass0), 0);
      repeat (2) @(negedge clk);

      // start pulses during the run are ignored
      sel = 2'd0;
      run0(4'b0110, 3, 8, lat);
      chk("s3_latency", 32'(lat), 9);
      chk("s3_pass", 32'(pass0), 1);
      chk("s3_err",  32'(err0),  0);
      nd = 0;
      repeat (6) begin
         @(negedge clk);
         if (done0) nd++;
      end
      chk("s3_extra_done", 32'(nd), 0);

      // reset in the middle of a run
      sel = 2'd1;
      @(negedge clk);
      exp0 = 4'b0110; start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("s4_busy", 32'(busy0), 0);
      chk("s4_stim", 32'(stim0), 0);
      chk("s4_err",  32'(err0),  0);
      chk("s4_fv",   32'(fv0),   0);
      nd = 0;
      repeat (12) begin
         @(negedge clk);
         if (done0) nd++;
      end
      chk("s4_no_done", 32'(nd), 0);
      sel = 2'd0;
      run0(4'b0110, 0, 0, lat);
      chk("s4_rerun_lat",  32'(lat), 9);
      chk("s4_rerun_pass", 32'(pass0), 1);
      repeat (2) @(negedge clk);

      // registered DUT: enough settle time vs. too little
      run1(4'b0110, lat);
      chk("s5_latency", 32'(lat), 17);
      chk("s5_pass", 32'(pass1), 1);
      chk("s5_err",  32'(err1),  0);
      sel = 2'd3;
      run0(4'b0110, 0, 0, lat);
      chk("s5_short_fail", 32'(err0 != 3'd0), 1);
      chk("s5_short_pass", 32'(pass0), 0);
      repeat (2) @(negedge clk);

      // constant-0 DUT: matching table, then all-ones table clears earlier results
      sel = 2'd2;
      run0(4'b0000, 0, 0, lat);
      chk("s6a_pass", 32'(pass0), 1);
      repeat (2) @(negedge clk);
      run0(4'b1111, 0, 0, lat);
      chk("s6b_err",  32'(err0),  4);
      chk("s6b_ffi",  32'(ffi0),  0);
      chk("s6b_fv",   32'(fv0),   1);
      chk("s6b_pass", 32'(pass0), 0);
      repeat (2) @(negedge clk);

      // start held high re-triggers after each FINISH with one idle cycle between runs
      sel = 2'd0;
      @(negedge clk);
      exp0 = 4'b0110; start0 = 1'b1;
      nd = 0;
      repeat (22) begin
         @(negedge clk);
         if (done0) nd++;
      end
      chk("s7_retrigger_dones", 32'(nd), 2);
      start0 = 1'b0;
      repeat (15) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
